// File: rtl/vga_line_fetcher.sv
// Linear frame-buffer fetcher for one arbiter read slot.
// Buffers returned bytes in a FIFO that the pixel generator drains.
module vga_line_fetcher #(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 8,
  parameter int HBYTES = 640,
  parameter int VLINES = 480,
  parameter int FDEPTH = 16,
  localparam int LW = $clog2(FDEPTH) + 1
) (
  input  logic              MemClk,
  input  logic              ResetN,
  input  logic              Enable,
  input  logic              FrameStart,
  input  logic [AWIDTH-1:0] BaseAddr,
  output logic [AWIDTH-1:0] ReqAddr,
  input  logic [DWIDTH-1:0] ReadData,
  input  logic              ReadDataRdy,
  input  logic              PixelReq,
  output logic [DWIDTH-1:0] PixelData,
  output logic              PixelValid,
  output logic [LW-1:0]     FifoLevel,
  output logic              LineDone,
  output logic              FrameDone,
  output logic              Underrun
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = $clog2(HBYTES + 1);
  localparam int RW = $clog2(VLINES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DWIDTH-1:0] mem [FDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     col;
  logic [RW-1:0]     line;

  logic fetching;
  logic restart;
  logic pop;
  logic room;
  logic push;
  logic col_last;
  logic line_last;

  always_ff @(posedge MemClk or negedge ResetN) begin
    if (!ResetN) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (restart)
      state_nx = S_FETCH;
    else if (push && col_last && line_last)
      state_nx = S_DONE;
  end

  always_comb begin
    fetching  = (state == S_FETCH);
    FrameDone = (state == S_DONE);
  end

  // FrameStart in IDLE only counts when fetching is enabled
  always_comb begin
    restart   = FrameStart && ((state != S_IDLE) || Enable);
    pop       = PixelReq && (FifoLevel != '0);
    room      = (FifoLevel < LW'(FDEPTH)) || pop;
    push      = fetching && ReadDataRdy && room && !restart;
    col_last  = (col == CW'(HBYTES - 1));
    line_last = (line == RW'(VLINES - 1));
  end

  always_ff @(posedge MemClk) begin
    if (push) mem[wr_ptr] <= ReadData;
  end

  always_ff @(posedge MemClk or negedge ResetN) begin
    if (!ResetN) begin
      ReqAddr    <= '0;
      PixelData  <= '0;
      PixelValid <= 1'b0;
      FifoLevel  <= '0;
      LineDone   <= 1'b0;
      Underrun   <= 1'b0;
      col        <= '0;
      line       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      PixelValid <= pop;
      if (pop) PixelData <= mem[rd_ptr];
      if (restart) begin
        ReqAddr   <= BaseAddr;
        FifoLevel <= '0;
        LineDone  <= 1'b0;
        Underrun  <= 1'b0;
        col       <= '0;
        line      <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else begin
        LineDone <= push && col_last;
        if (PixelReq && (FifoLevel == '0)) Underrun <= 1'b1;
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          ReqAddr <= ReqAddr + AWIDTH'(1);
          if (col_last) begin
            col  <= '0;
            line <= line_last ? '0 : line + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        if (push && !pop)      FifoLevel <= FifoLevel + LW'(1);
        else if (pop && !push) FifoLevel <= FifoLevel - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Randomized bench for vga_line_fetcher with a queue-based frame model
// and a scoreboard monitor for popped pixels.
module tb_vga_line_fetcher;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int HB = 4;
  localparam int VL = 2;
  localparam int FD = 4;
  localparam int LW = $clog2(FD) + 1;

  logic          MemClk;
  logic          ResetN;
  logic          Enable;
  logic          FrameStart;
  logic [AW-1:0] BaseAddr;
  logic [AW-1:0] ReqAddr;
  logic [DW-1:0] ReadData;
  logic          ReadDataRdy;
  logic          PixelReq;
  logic [DW-1:0] PixelData;
  logic          PixelValid;
  logic [LW-1:0] FifoLevel;
  logic          LineDone;
  logic          FrameDone;
  logic          Underrun;

  vga_line_fetcher #(
    .AWIDTH(AW), .DWIDTH(DW), .HBYTES(HB), .VLINES(VL), .FDEPTH(FD)
  ) dut (
    .MemClk(MemClk), .ResetN(ResetN), .Enable(Enable),
    .FrameStart(FrameStart), .BaseAddr(BaseAddr), .ReqAddr(ReqAddr),
    .ReadData(ReadData), .ReadDataRdy(ReadDataRdy), .PixelReq(PixelReq),
    .PixelData(PixelData), .PixelValid(PixelValid), .FifoLevel(FifoLevel),
    .LineDone(LineDone), .FrameDone(FrameDone), .Underrun(Underrun)
  );

  initial begin
    MemClk = 1'b0;
    forever #5 MemClk = ~MemClk;
  end

  int checks = 0;
  int failures = 0;

  // reference model: byte queue plus position within the frame
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] m_addr;
  int            m_pos;
  bit            m_run, m_done, m_ld, m_und, m_pv;
  bit            mon_en = 0;
  bit            in_reset = 0;
  logic [DW-1:0] last_pd;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dbyte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_addr = '0;
    m_pos = 0;
    m_run = 0;
    m_done = 0;
    m_ld = 0;
    m_und = 0;
    m_pv = 0;
    last_pd = '0;
  endtask

  task automatic model_step();
    bit pop, push;
    if (in_reset) return;
    pop = PixelReq && (mq.size() > 0);
    if (FrameStart && (m_run || m_done || Enable)) begin
      mq.delete();
      m_addr = BaseAddr;
      m_pos = 0;
      m_run = 1;
      m_done = 0;
      m_und = 0;
      m_ld = 0;
      m_pv = 0;
    end else begin
      push = m_run && ReadDataRdy && ((mq.size() < FD) || pop);
      m_ld = 0;
      m_pv = pop;
      if (pop) exp_q.push_back(mq.pop_front());
      else if (PixelReq) m_und = 1;
      if (push) begin
        mq.push_back(ReadData);
        m_addr = m_addr + 1'b1;
        m_pos++;
        if (m_pos % HB == 0) m_ld = 1;
        if (m_pos == HB * VL) begin
          m_run = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit fs, input bit en, input logic [AW-1:0] base,
                       input bit rdy, input bit preq);
    @(negedge MemClk);
    FrameStart  = fs;
    Enable      = en;
    BaseAddr    = base;
    ReadDataRdy = rdy;
    PixelReq    = preq && !fs;
    ReadData    = dbyte(m_addr);
    model_step();
  endtask

  task automatic settle();
    @(posedge MemClk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_addr"}, ReqAddr, 0);
    chk({tag, "_level"}, FifoLevel, 0);
    chk({tag, "_pdata"}, PixelData, 0);
    chk({tag, "_pvalid"}, PixelValid, 0);
    chk({tag, "_linedone"}, LineDone, 0);
    chk({tag, "_framedone"}, FrameDone, 0);
    chk({tag, "_underrun"}, Underrun, 0);
  endtask

  // monitor: compares every cycle, pops scoreboard on each PixelValid
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(posedge MemClk);
      #1;
      if (mon_en) begin
        chk("req_addr", ReqAddr, m_addr);
        chk("fifo_level", FifoLevel, mq.size());
        chk("line_done", LineDone, m_ld);
        chk("frame_done", FrameDone, m_done);
        chk("underrun", Underrun, m_und);
        chk("pixel_valid", PixelValid, m_pv);
        if (PixelValid) begin
          if (exp_q.size() == 0) begin
            chk("pixel_unexpected", PixelValid, 0);
          end else begin
            e = exp_q.pop_front();
            last_pd = e;
            chk("pixel_data", PixelData, e);
          end
        end else begin
          chk("pixel_hold", PixelData, last_pd);
        end
      end
    end
  end

  initial begin
    ResetN = 1'b1;
    Enable = 1'b0;
    FrameStart = 1'b0;
    BaseAddr = '0;
    ReadData = '0;
    ReadDataRdy = 1'b0;
    PixelReq = 1'b0;
    model_reset();
    #2 ResetN = 1'b0;
    #1 reset_checks("init_reset");
    @(negedge MemClk);
    @(negedge MemClk);
    ResetN = 1'b1;
    mon_en = 1;

    // frame walk with pops between strobes
    cycle(1, 1, 19'h100, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 19'h0, 1, 0);
      if (i == 3) begin
        settle();
        chk("walk_linedone_4th", LineDone, 1);
      end
      cycle(0, 1, 19'h0, 0, 1);
    end
    settle();
    chk("walk_end_addr", ReqAddr, 19'h108);
    chk("walk_framedone", FrameDone, 1);
    cycle(0, 1, 19'h0, 1, 0);

    // fill: 6 strobes, only 4 accepted
    cycle(1, 1, 19'h200, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 19'h0, 1, 0);
    settle();
    chk("full_level", FifoLevel, 4);
    chk("full_addr", ReqAddr, 19'h204);
    cycle(0, 1, 19'h0, 0, 1);
    cycle(0, 1, 19'h0, 1, 0);
    settle();
    chk("refill_addr", ReqAddr, 19'h205);

    // push and pop together on a full FIFO
    for (int i = 0; i < 3; i++) cycle(0, 1, 19'h0, 1, 1);
    settle();
    chk("pushpop_level", FifoLevel, 4);
    chk("pushpop_addr", ReqAddr, 19'h208);

    // drain then underrun
    for (int i = 0; i < 5; i++) cycle(0, 1, 19'h0, 0, 1);
    settle();
    chk("underrun_set", Underrun, 1);
    chk("underrun_pvalid", PixelValid, 0);
    cycle(1, 1, 19'h300, 0, 0);
    settle();
    chk("underrun_clear", Underrun, 0);

    // restart mid-line with 3 bytes buffered and a concurrent strobe
    for (int i = 0; i < 3; i++) cycle(0, 1, 19'h0, 1, 0);
    cycle(1, 1, 19'h400, 1, 0);
    settle();
    chk("restart_level", FifoLevel, 0);
    chk("restart_addr", ReqAddr, 19'h400);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 19'h0, 1, 0);
      cycle(0, 1, 19'h0, 0, 1);
    end

    // address wrap
    cycle(1, 1, 19'h7FFFE, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 19'h0, 1, 0);
      cycle(0, 1, 19'h0, 0, 1);
    end
    settle();
    chk("wrap_addr", ReqAddr, 19'h2);

    // asynchronous reset mid-frame
    cycle(1, 1, 19'h600, 0, 0);
    cycle(0, 1, 19'h0, 1, 0);
    cycle(0, 1, 19'h0, 1, 1);
    cycle(0, 1, 19'h0, 0, 0);
    #3;
    ResetN = 1'b0;
    in_reset = 1;
    model_reset();
    #1 reset_checks("mid_reset");
    cycle(0, 1, 19'h0, 1, 1);
    cycle(0, 1, 19'h0, 0, 0);
    @(negedge MemClk);
    ResetN = 1'b1;
    in_reset = 0;
    cycle(1, 0, 19'h500, 0, 0);
    cycle(0, 0, 19'h0, 1, 0);
    cycle(0, 1, 19'h0, 1, 0);
    settle();
    chk("idle_addr", ReqAddr, 0);
    chk("idle_level", FifoLevel, 0);
    chk("idle_framedone", FrameDone, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [AW-1:0] b;
      b = ($urandom_range(0, 3) == 0) ? AW'(19'h7FFFC + $urandom_range(0, 3))
                                     : AW'($urandom);
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, b,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4);
    end
    cycle(0, 0, 19'h0, 0, 0);
    settle();
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
